dvp_camera_tx: RTL and testbench

//  OV5640-style DVP video source: emits VSYNC/HREF/8-bit data exactly as a camera does, one byte per clk.

---
 rtl/dvp_tx_pkg.sv | 37 +++
 rtl/dvp_bar_gen.sv | 56 +++++
 rtl/dvp_camera_tx.sv | 212 +++++++++++++++++++++
 tb/tb_dvp_camera_tx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dvp_tx_pkg.sv
// Shared types and helpers for the DVP camera transmitter: FSM state encoding,
// the 8-entry RGB565 colour-bar table and the line length derivation.
package dvp_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StVsync,
    StVbp,
    StActive,
    StVfp
  } dvp_state_e;

  localparam int unsigned NumBars = 8;

  // RGB565 colour of bars 0..7: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = 16'hFFFF;
      3'd1:    c = 16'hFFE0;
      3'd2:    c = 16'h07FF;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'hF81F;
      3'd5:    c = 16'hF800;
      3'd6:    c = 16'h001F;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  // Clock cycles per line: two bytes per active pixel plus horizontal blanking.
  function automatic int unsigned line_len(input int unsigned h_active,
                                           input int unsigned h_blank);
    return 2 * h_active + h_blank;
  endfunction

endpackage

// File: rtl/dvp_bar_gen.sv
// Colour-bar generator. Tracks the pixel position within the active line with a
// bar-width counter plus a 3-bit bar index, and returns the colour of the pixel
// selected by this cycle's strobes (line_start_i / pix_adv_i) so the caller can
// register the matching byte on the same edge.
module dvp_bar_gen
  import dvp_tx_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        line_start_i,
  input  logic        pix_adv_i,
  input  logic [2:0]  offset_i,
  output logic [15:0] colour_o
);

  localparam int unsigned BarPix = H_ACTIVE / NumBars;
  localparam int unsigned PixW = (BarPix > 1) ? $clog2(BarPix) : 1;
  localparam logic [PixW-1:0] PixLast = PixW'(BarPix - 1);

  logic [PixW-1:0] pix_q, pix_d;
  logic [2:0]      bar_q, bar_d;

  // Next pixel position: restart at bar 0 on a new line, step on each new pixel.
  always_comb begin
    pix_d = pix_q;
    bar_d = bar_q;
    if (line_start_i) begin
      pix_d = '0;
      bar_d = '0;
    end else if (pix_adv_i) begin
      if (pix_q == PixLast) begin
        pix_d = '0;
        bar_d = bar_q + 3'd1;
      end else begin
        pix_d = pix_q + 1'b1;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_q <= '0;
      bar_q <= '0;
    end else begin
      pix_q <= pix_d;
      bar_q <= bar_d;
    end
  end

  // The offset rotates which colour appears in each bar position (wraps mod 8).
  assign colour_o = bar_colour(bar_d + offset_i);

endmodule

// File: rtl/dvp_camera_tx.sv
// OV5640-style DVP video source: VSYNC / HREF / 8-bit RGB565 data (high byte
// first), one byte per clk, showing an internal 8-bar colour pattern.
// Optional feature macro: DVP_TX_SCROLL_EN -- when defined the bars rotate by
// one position per frame using frame_cnt[2:0] latched at frame start.
// All outputs are registered from next-state values, so the first VSYNC cycle
// appears the cycle after enable is sampled in idle.
module dvp_camera_tx
  import dvp_tx_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = 1024,
  parameter int unsigned V_ACTIVE  = 768,
  parameter int unsigned H_BLANK   = 256,
  parameter int unsigned VS_LINES  = 4,
  parameter int unsigned VBP_LINES = 16,
  parameter int unsigned VFP_LINES = 4,
  parameter logic        VS_POL    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam int unsigned LineLen = line_len(H_ACTIVE, H_BLANK);
  localparam int unsigned ColW = $clog2(LineLen);
  localparam int unsigned MaxA = (VS_LINES > VBP_LINES) ? VS_LINES : VBP_LINES;
  localparam int unsigned MaxB = (V_ACTIVE > VFP_LINES) ? V_ACTIVE : VFP_LINES;
  localparam int unsigned MaxLines = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned LineW = (MaxLines > 1) ? $clog2(MaxLines) : 1;

  localparam logic [ColW-1:0] ColLast = ColW'(LineLen - 1);
  localparam logic [ColW-1:0] HrefCols = ColW'(2 * H_ACTIVE);

  // Empty phases are skipped by jumping straight to the next populated one.
  localparam dvp_state_e FirstPhase = (VS_LINES != 0)  ? StVsync :
                                      (VBP_LINES != 0) ? StVbp : StActive;
  localparam dvp_state_e AfterVsync = (VBP_LINES != 0) ? StVbp : StActive;
  localparam dvp_state_e LastPhase  = (VFP_LINES != 0) ? StVfp : StActive;

  function automatic logic [LineW-1:0] last_line(input dvp_state_e s);
    logic [LineW-1:0] r;
    case (s)
      StVsync:  r = LineW'(VS_LINES - 1);
      StVbp:    r = LineW'(VBP_LINES - 1);
      StActive: r = LineW'(V_ACTIVE - 1);
      StVfp:    r = LineW'(VFP_LINES - 1);
      default:  r = '0;
    endcase
    return r;
  endfunction

  dvp_state_e       state_q, state_d;
  logic [ColW-1:0]  col_q, col_d;
  logic [LineW-1:0] line_q, line_d;
  logic             frame_start;

  logic             vsync_d, href_d, frame_done_d, busy_d;
  logic [7:0]       data_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic             line_start, pix_adv;
  logic [2:0]       offset;
  logic [15:0]      colour;

  // Timing FSM: column/line counters and phase sequencing.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    line_d      = line_q;
    frame_start = 1'b0;
    case (state_q)
      StIdle: begin
        if (enable) begin
          state_d     = FirstPhase;
          col_d       = '0;
          line_d      = '0;
          frame_start = 1'b1;
        end
      end
      default: begin
        if (col_q == ColLast) begin
          col_d = '0;
          if (line_q == last_line(state_q)) begin
            line_d = '0;
            if (state_q == LastPhase) begin
              // Enable only matters here: frames always run to completion.
              if (enable) begin
                state_d     = FirstPhase;
                frame_start = 1'b1;
              end else begin
                state_d = StIdle;
              end
            end else begin
              case (state_q)
                StVsync:  state_d = AfterVsync;
                StVbp:    state_d = StActive;
                default:  state_d = StVfp;
              endcase
            end
          end else begin
            line_d = line_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    endcase
  end

  // FSM and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      col_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      line_q  <= line_d;
    end
  end

`ifdef DVP_TX_SCROLL_EN
  logic [2:0] offset_q, offset_d;

  // Capture the frame count on frame entry so a frame never mixes two offsets.
  always_comb begin
    offset_d = offset_q;
    if (frame_start) begin
      offset_d = frame_cnt_q[2:0];
    end
  end

  // Offset register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset_q <= '0;
    end else begin
      offset_q <= offset_d;
    end
  end

  assign offset = offset_d;
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign offset = 3'd0;
`endif

  // Strobes for the byte being registered this edge (col_d is that byte's column).
  assign line_start = (state_d == StActive) && (col_d == '0);
  assign pix_adv    = (state_d == StActive) && (col_d != '0) && !col_d[0] && (col_d < HrefCols);

  dvp_bar_gen #(
    .H_ACTIVE (H_ACTIVE)
  ) u_bar_gen (
    .clk          (clk),
    .rst          (rst),
    .line_start_i (line_start),
    .pix_adv_i    (pix_adv),
    .offset_i     (offset),
    .colour_o     (colour)
  );

  // Next output values derived from the next FSM position.
  always_comb begin
    vsync_d      = (state_d == StVsync) ? VS_POL : ~VS_POL;
    href_d       = (state_d == StActive) && (col_d < HrefCols);
    data_d       = 8'h00;
    if (href_d) begin
      data_d = col_d[0] ? colour[7:0] : colour[15:8];
    end
    busy_d       = (state_d != StIdle);
    frame_done_d = (state_d == LastPhase) && (line_d == last_line(LastPhase)) &&
                   (col_d == ColLast);
    frame_cnt_d  = frame_cnt_q + 16'd1;
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cam_vsync  <= ~VS_POL;
      cam_href   <= 1'b0;
      cam_data   <= 8'h00;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cam_vsync  <= vsync_d;
      cam_href   <= href_d;
      cam_data   <= data_d;
      frame_done <= frame_done_d;
      busy       <= busy_d;
    end
  end

  // Completed-frame counter; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= 16'h0000;
    end else if (frame_done_d) begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_dvp_camera_tx.sv
// Self-checking bench for dvp_camera_tx. A frame-position reference model
// predicts every output each cycle from line/column arithmetic; directed
// phases cover enable drop, back-to-back frames, async reset and counter wrap,
// with a randomized enable phase in between.
module tb_dvp_camera_tx;

  localparam int H     = 16;
  localparam int V     = 4;
  localparam int HB    = 8;
  localparam int VS    = 1;
  localparam int VBP   = 2;
  localparam int VFP   = 1;
  localparam int LINE  = 2 * H + HB;
  localparam int FRAME = (VS + VBP + V + VFP) * LINE;

  localparam logic [15:0] Colours [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                          16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        cam_vsync, cam_href, frame_done, busy;
  logic [7:0]  cam_data;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  dvp_camera_tx #(
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .H_BLANK   (HB),
    .VS_LINES  (VS),
    .VBP_LINES (VBP),
    .VFP_LINES (VFP),
    .VS_POL    (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .busy       (busy)
  );

  int total = 0;
  int bad = 0;
  int fd_count = 0;

  // Reference model: running flag, position within the frame, frame count, offset.
  logic        m_run = 1'b0;
  int          m_pos = 0;
  logic [15:0] m_cnt = 16'h0000;
  int          m_off = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_pos = 0;
    m_cnt = 16'h0000;
    m_off = 0;
  endtask

  function automatic int frame_offset(input logic [15:0] cnt);
`ifdef DVP_TX_SCROLL_EN
    return int'(cnt[2:0]);
`else
    return 0 * int'(cnt[0]);
`endif
  endfunction

  task automatic model_edge(input logic en);
    if (!m_run) begin
      if (en) begin
        m_run = 1'b1;
        m_pos = 0;
        m_off = frame_offset(m_cnt);
      end
    end else if (m_pos == FRAME - 1) begin
      if (en) begin
        m_pos = 0;
        m_off = frame_offset(m_cnt);
      end else begin
        m_run = 1'b0;
        m_pos = 0;
      end
    end else begin
      m_pos++;
    end
    if (m_run && m_pos == FRAME - 1) m_cnt = m_cnt + 16'd1;
  endtask

  function automatic logic model_in_active();
    int line = m_pos / LINE;
    return m_run && line >= VS + VBP && line < VS + VBP + V && (m_pos % LINE) < 2 * H;
  endfunction

  task automatic compare_outputs();
    int          line, col, bar;
    logic [15:0] c;
    logic [7:0]  d;
    logic        v, h;
    line = m_pos / LINE;
    col  = m_pos % LINE;
    v    = m_run && line < VS;
    h    = model_in_active();
    bar  = ((col / 2) / (H / 8) + m_off) % 8;
    c    = Colours[bar];
    d    = h ? ((col % 2 == 1) ? c[7:0] : c[15:8]) : 8'h00;
    check("vsync", 32'(cam_vsync), 32'(v));
    check("href", 32'(cam_href), 32'(h));
    check("data", 32'(cam_data), 32'(d));
    check("frame_done", 32'(frame_done), 32'(m_run && m_pos == FRAME - 1));
    check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    check("busy", 32'(busy), 32'(m_run));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(enable);
    #1;
    if (frame_done === 1'b1) fd_count++;
    compare_outputs();
  endtask

  initial begin
    logic found;

    // Reset state.
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();

    // Enable held, then dropped during the second active line.
    enable = 1'b1;
    repeat ((VS + VBP + 1) * LINE + 1) tick();
    enable = 1'b0;
    repeat (FRAME + 100) tick();
    check("drop_cnt", 32'(frame_cnt), 32'd1);
    check("drop_busy", 32'(busy), 32'd0);

    // Three back-to-back frames.
    enable = 1'b1;
    repeat (3 * FRAME - 5) tick();
    enable = 1'b0;
    repeat (FRAME) tick();
    check("b2b_cnt", 32'(frame_cnt), 32'd4);

    // Randomized enable toggling.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      tick();
    end

    // Asynchronous reset in the middle of an active line.
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME + 10 && !found; i++) begin
      tick();
      found = model_in_active() && (m_pos % LINE) > 4;
    end
    check("rst_reach_active", 32'(found), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("rst_vsync", 32'(cam_vsync), 32'd0);
    check("rst_href", 32'(cam_href), 32'd0);
    check("rst_data", 32'(cam_data), 32'd0);
    check("rst_cnt", 32'(frame_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
    repeat (FRAME - 10) tick();
    enable = 1'b0;
    repeat (FRAME) tick();
    check("post_rst_cnt", 32'(frame_cnt), 32'd1);

    // Counter wrap from 16'hFFFF while idle.
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    m_cnt = 16'hFFFF;
    tick();
    check("wrap_pre", 32'(frame_cnt), 32'h0000FFFF);
    fd_count = 0;
    enable = 1'b1;
    repeat (FRAME - 10) tick();
    enable = 1'b0;
    repeat (FRAME) tick();
    check("wrap_cnt", 32'(frame_cnt), 32'd0);
    check("wrap_pulses", 32'(fd_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
